// File: rtl/serial_pattern_detector_mc.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector_mc
//
// Multi-channel serial sequence detector. Each of CH bit streams is shifted
// MSB-first into its own history register and compared against one shared,
// runtime-loadable pattern of PAT_LEN bits. Matches produce a registered
// one-cycle pulse on z[c] and bump a per-channel saturating counter.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (overrides every other input)
//   en         bit-valid strobe shared by all channels
//   din        serial data, din[c] belongs to channel c
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   pat_load   load pat_in into the pattern register (priority over en)
//   pat_in     new pattern, bit PAT_LEN-1 is the first bit received
//   cnt_clr    clear all match counters (a same-cycle match still counts)
//   z          registered one-cycle match pulse per channel
//   match_cnt  per-channel saturating counts, channel c at [c*CNT_W +: CNT_W]
//   pat_q      current pattern register
// -----------------------------------------------------------------------------
module serial_pattern_detector_mc #(
    parameter int                   CH      = 2,
    parameter int                   PAT_LEN = 8,
    parameter int                   CNT_W   = 8,
    parameter logic [PAT_LEN-1:0]   PAT_RST = 8'b1011_0111
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [CH-1:0]           din,
    input  logic                    overlap,
    input  logic                    pat_load,
    input  logic [PAT_LEN-1:0]      pat_in,
    input  logic                    cnt_clr,
    output logic [CH-1:0]           z,
    output logic [CH*CNT_W-1:0]     match_cnt,
    output logic [PAT_LEN-1:0]      pat_q
);

    localparam int                  FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Shared pattern register
    // ------------------------------------------------------------------
    logic [PAT_LEN-1:0] pat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg <= PAT_RST;
        end else if (pat_load) begin
            pat_reg <= pat_in;
        end
    end

    assign pat_q = pat_reg;

    // ------------------------------------------------------------------
    // Per-channel detector
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t             state_reg, state_next;
            // Only the newest PAT_LEN-1 bits are kept: the oldest bit of a
            // full window is shifted out on the next sample and can never
            // take part in a later match, so it does not need storage.
            logic [PAT_LEN-2:0] hist_reg, hist_next;
            logic [PAT_LEN-1:0] hist_shift;
            logic [FILL_W-1:0]  fill_reg, fill_next, fill_inc;
            logic               match;
            logic               z_reg, z_next;
            logic [CNT_W-1:0]   cnt_reg, cnt_next;

            // State register (FSM state plus the channel datapath)
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= FILL;
                    hist_reg  <= '0;
                    fill_reg  <= '0;
                    z_reg     <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    hist_reg  <= hist_next;
                    fill_reg  <= fill_next;
                    z_reg     <= z_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next-state logic
            always_comb begin
                hist_shift = {hist_reg, din[gi]};
                // Once ARMED the window is full and stays full.
                fill_inc   = (state_reg == ARMED) ? FILL_FULL
                                                  : fill_reg + FILL_W'(1);
                match      = en && !pat_load && (fill_inc == FILL_FULL)
                             && (hist_shift == pat_reg);

                state_next = state_reg;
                hist_next  = hist_reg;
                fill_next  = fill_reg;

                if (pat_load) begin
                    // New pattern: restart every channel from an empty window.
                    state_next = FILL;
                    hist_next  = '0;
                    fill_next  = '0;
                end else if (en) begin
                    hist_next = hist_shift[PAT_LEN-2:0];
                    if (match && !overlap) begin
                        // Non-overlapping: the next match needs a fresh window.
                        state_next = FILL;
                        fill_next  = '0;
                    end else begin
                        fill_next  = fill_inc;
                        state_next = (fill_inc == FILL_FULL) ? ARMED : FILL;
                    end
                end
            end

            // Output logic
            always_comb begin
                z_next   = match;
                cnt_next = cnt_reg;
                if (cnt_clr) begin
                    // Clear first, then count a same-cycle match.
                    cnt_next = match ? CNT_W'(1) : '0;
                end else if (match && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            assign z[gi]                        = z_reg;
            assign match_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_serial_pattern_detector_mc.sv
module tb_serial_pattern_detector_mc;

    localparam int         CH = 2;
    localparam int         PL = 4;
    localparam int         CW = 2;
    localparam logic [3:0] PR = 4'b1011;

    logic          clk = 1'b0;
    logic          rst, en, overlap, pat_load, cnt_clr;
    logic [1:0]    din;
    logic [3:0]    pat_in;
    logic [1:0]    z;
    logic [3:0]    match_cnt;
    logic [3:0]    pat_q;

    int total = 0;
    int bad   = 0;

    serial_pattern_detector_mc #(
        .CH      (CH),
        .PAT_LEN (PL),
        .CNT_W   (CW),
        .PAT_RST (PR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .z         (z),
        .match_cnt (match_cnt),
        .pat_q     (pat_q)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per-channel queue of bits received since the window
    // was last emptied; a match is the last PAT_LEN bits equal to pattern.
    // ------------------------------------------------------------------
    bit         hq [CH][$];
    logic [1:0] m_z;
    int         m_cnt [CH];
    logic [3:0] m_pat;

    task automatic model_edge(input bit r, input bit e, input bit [1:0] d,
                              input bit o, input bit l, input bit [3:0] p,
                              input bit c);
        if (r) begin
            m_pat = PR;
            m_z   = 2'b00;
            for (int ch = 0; ch < CH; ch++) begin
                hq[ch].delete();
                m_cnt[ch] = 0;
            end
            return;
        end
        m_z = 2'b00;
        for (int ch = 0; ch < CH; ch++) begin
            bit m;
            int v;
            m = 1'b0;
            if (l) begin
                hq[ch].delete();
            end else if (e) begin
                hq[ch].push_back(d[ch]);
                if (hq[ch].size() > PL) void'(hq[ch].pop_front());
                if (hq[ch].size() == PL) begin
                    v = 0;
                    for (int i = 0; i < PL; i++) v = (v << 1) | int'(hq[ch][i]);
                    m = (v == int'(m_pat));
                end
                if (m && !o) hq[ch].delete();
            end
            m_z[ch] = m;
            if (c)                             m_cnt[ch] = m ? 1 : 0;
            else if (m && m_cnt[ch] < (1 << CW) - 1) m_cnt[ch]++;
        end
        if (l) m_pat = p;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge.
    task automatic apply(input bit r, input bit e, input bit [1:0] d,
                         input bit o, input bit l, input bit [3:0] p,
                         input bit c);
        rst = r; en = e; din = d; overlap = o; pat_load = l; pat_in = p;
        cnt_clr = c;
        model_edge(r, e, d, o, l, p, c);
        @(posedge clk);
        #1;
        check("model_z",    32'(z),               32'(m_z));
        check("model_cnt0", 32'(match_cnt[1:0]),  32'(m_cnt[0]));
        check("model_cnt1", 32'(match_cnt[3:2]),  32'(m_cnt[1]));
        check("model_pat",  32'(pat_q),           32'(m_pat));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table with hand-derived expectations
    // ------------------------------------------------------------------
    typedef struct {
        bit       r;
        bit       e;
        bit [1:0] d;
        bit       o;
        bit       l;
        bit [3:0] p;
        bit       c;
        bit [1:0] ez;
        bit [1:0] ec0;
        bit [1:0] ec1;
        bit [3:0] ep;
    } vec_t;

    vec_t vecs[$];
    int   build_cnt;

    task automatic add(input bit r, input bit e, input bit [1:0] d,
                       input bit o, input bit l, input bit [3:0] p,
                       input bit c, input bit [1:0] ez, input bit [1:0] ec0,
                       input bit [1:0] ec1, input bit [3:0] ep);
        vec_t t;
        t.r = r; t.e = e; t.d = d; t.o = o; t.l = l; t.p = p; t.c = c;
        t.ez = ez; t.ec0 = ec0; t.ec1 = ec1; t.ep = ep;
        vecs.push_back(t);
    endtask

    // Channel-0 stream sent MSB first; zm marks the bits that complete a match.
    task automatic add_stream(input logic [15:0] s, input logic [15:0] zm,
                              input int n, input bit o);
        for (int i = n - 1; i >= 0; i--) begin
            if (zm[i]) build_cnt = (build_cnt < 3) ? build_cnt + 1 : 3;
            add(1'b0, 1'b1, {1'b0, s[i]}, o, 1'b0, 4'h0, 1'b0,
                {1'b0, zm[i]}, 2'(build_cnt), 2'd0, PR);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 2'b00; overlap = 1'b1; pat_load = 1'b0;
        pat_in = 4'h0; cnt_clr = 1'b0;

        // 1: single match on ch0, ch1 silent
        add(1,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b01,1,0,PR);
        add(0,0,2'b00,1,0,4'h0,0, 2'b00,1,0,PR);
        // 2: overlap and non-overlap on 1,0,1,1,0,1,1,1,0,1,1
        add(1,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        build_cnt = 0;
        add_stream(16'b101_1011_1011, 16'b000_1001_0001, 11, 1'b1);
        add(1,0,2'b00,0,0,4'h0,0, 2'b00,0,0,PR);
        build_cnt = 0;
        add_stream(16'b101_1011_1011, 16'b000_1000_0001, 11, 1'b0);
        // 3: en gaps with toggling din
        add(1,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,0,2'b11,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,0,2'b11,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b01,1,0,PR);
        // 5: saturation, clear with a match, clear alone
        add(1,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        build_cnt = 0;
        add_stream(16'b1011_0110_1101_1011, 16'b0001_0010_0100_1001, 16, 1'b1);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,3,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,3,0,PR);
        add(0,1,2'b01,1,0,4'h0,1, 2'b01,1,0,PR);
        add(0,0,2'b00,1,0,4'h0,1, 2'b00,0,0,PR);
        // 4: pattern reload mid-stream
        add(1,0,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,1,4'b0110,0, 2'b00,0,0,4'b0110);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,4'b0110);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,0,0,4'b0110);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,4'b0110);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,4'b0110);
        add(0,1,2'b00,1,0,4'h0,0, 2'b01,1,0,4'b0110);
        // 6: reset mid-stream (en=1 in the reset cycle is ignored)
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,1,0,4'b0110);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,1,0,4'b0110);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,1,0,4'b0110);
        add(1,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b00,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b00,0,0,PR);
        add(0,1,2'b01,1,0,4'h0,0, 2'b01,1,0,PR);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].o, vecs[i].l,
                  vecs[i].p, vecs[i].c);
            check($sformatf("vec%0d_z", i),    32'(z),              32'(vecs[i].ez));
            check($sformatf("vec%0d_cnt0", i), 32'(match_cnt[1:0]), 32'(vecs[i].ec0));
            check($sformatf("vec%0d_cnt1", i), 32'(match_cnt[3:2]), 32'(vecs[i].ec1));
            check($sformatf("vec%0d_pat", i),  32'(pat_q),          32'(vecs[i].ep));
            $display("vec %0d: rst=%b en=%b din=%b ovl=%b ld=%b clr=%b -> z=%b cnt=%h pat=%h",
                     i, vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].o, vecs[i].l,
                     vecs[i].c, z, match_cnt, pat_q);
        end

        // Randomized traffic against the reference model
        begin
            bit ovl_r;
            ovl_r = 1'b1;
            for (int n = 0; n < 600; n++) begin
                bit       r, e, l, c;
                bit [1:0] d;
                bit [3:0] p;
                r = ($urandom_range(0, 199) == 0);
                e = ($urandom_range(0, 3) != 0);
                d = 2'($urandom);
                if ($urandom_range(0, 19) == 0) ovl_r = ~ovl_r;
                l = ($urandom_range(0, 49) == 0);
                p = 4'($urandom);
                c = ($urandom_range(0, 29) == 0);
                apply(r, e, d, ovl_r, l, p, c);
                $display("rnd %0d: rst=%b en=%b din=%b ovl=%b ld=%b clr=%b -> z=%b cnt=%h pat=%h",
                         n, r, e, d, ovl_r, l, c, z, match_cnt, pat_q);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector_mc.md
Name: serial_pattern_detector_mc

Overview:
Multi-channel, parametrised serial sequence detector. It is the successor to the team's fixed two-input Mealy/Moore detector FSMs. Each of CH independent bit streams is compared MSB-first against one shared, runtime-loadable pattern of PAT_LEN bits. The block has a selectable overlap or non-overlap mode and a per-channel saturating match counter. It sits between the serial bit-capture front end and the status/interrupt logic.

Parameters:
- CH, 2, number of independent serial channels (1..8).
- PAT_LEN, 8, pattern length in bits (2..16).
- CNT_W, 8, width of each per-channel match counter (1..16).
- PAT_RST, 8'b1011_0111, pattern value loaded at reset (PAT_LEN bits wide).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  bit-valid strobe common to all channels; din is sampled only when en=1.
- din  input  CH  serial data; din[c] is channel c.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- pat_load  input  1  loads pat_in into the pattern register.
- pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
- cnt_clr  input  1  clears all match counters.
- z  output  CH  registered one-cycle match pulse per channel.
- match_cnt  output  CH*CNT_W  per-channel saturating match counts; channel c occupies bits [c*CNT_W +: CNT_W].
- pat_q  output  PAT_LEN  current pattern register.

Behaviour:
- Reset (rst=1 at a clock edge), which overrides every other input:
  - pat_q=PAT_RST;
  - all history registers, fill counters, z and match_cnt are cleared to 0;
  - every channel goes to FILL.
- Per-channel state:
  - hist[PAT_LEN-1:0] shift register, newest bit in the LSB;
  - fill counter, width $clog2(PAT_LEN+1), saturating at PAT_LEN;
  - 2-state FSM: FILL (fill<PAT_LEN) and ARMED (fill==PAT_LEN).
- On an en=1 edge (pat_load=0), for each channel c:
  - hist_n = {hist[PAT_LEN-2:0], din[c]};
  - fill_n = min(fill+1, PAT_LEN);
  - match = (fill_n==PAT_LEN) && (hist_n==pat_q).
- Latency: z[c] is 1 in the cycle after the edge that sampled the final pattern bit. It is high for exactly one cycle, then returns to 0.
- Overlap=1: after a match the channel stays ARMED, so a match can occur again as soon as the shifted history equals the pattern.
- Overlap=0: on a match, fill is forced to 0 and the channel goes to FILL. The next match requires PAT_LEN fresh bits.
- overlap is sampled at each en edge, so a mode change applies from the next sampled bit.
- en=0: hist, fill and FSM state hold; din is ignored; z=0 in the following cycle.
- pat_load=1 (has priority over en in the same cycle):
  - pat_q<=pat_in;
  - all hist and fill are cleared; all channels go to FILL;
  - the din sampled that cycle is discarded; z=0 in the next cycle;
  - match_cnt is unaffected.
- match_cnt[c]:
  - +1 on each match, saturating at 2^CNT_W-1 (no wrap);
  - cnt_clr alone sets it to 0;
  - cnt_clr in the same cycle as a match gives 1 (clear, then count).
- Channels are fully independent apart from the shared en, overlap, pattern and control inputs. Simultaneous matches on several channels all pulse in the same cycle.
- Reset mid-stream discards partial history; the first match after reset needs PAT_LEN new bits.

Test Plan:
All scenarios use CH=2, PAT_LEN=4, CNT_W=2, PAT_RST=4'b1011.
1. After reset, en=1 every cycle, din[0]=1,0,1,1 and din[1]=0,0,0,0:
   - z[0]=1 for one cycle, the cycle after the 4th bit; z[1] stays 0;
   - match_cnt ch0=1, ch1=0.
2. Stream 1,0,1,1,0,1,1,1,0,1,1 on ch0:
   - overlap=1: z[0] pulses after bits 4, 7 and 11; match_cnt ch0=3 (saturated).
   - Repeated after reset with overlap=0: pulses after bits 4 and 11 only; match_cnt ch0=2.
3. Bits 1,0 with en=1, then en=0 for 3 cycles with din toggling, then 1,1 with en=1:
   - exactly one z[0] pulse, after the last 1;
   - no pulses during the en=0 cycles.
4. Pattern reload mid-stream:
   - after bits 1,0,1, pulse pat_load with pat_in=4'b0110, then send 1 -> no match; pat_q=4'b0110;
   - then send 0,1,1,0 -> z[0] pulse after the final 0.
5. Counter saturation and clear:
   - five overlapping matches (1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1) -> match_cnt ch0 stays at 3;
   - cnt_clr asserted on the edge of a further match -> match_cnt ch0=1;
   - cnt_clr alone -> 0.
6. Reset mid-operation: after bits 1,0,1, assert rst for one cycle, then send 1:
   - no match; pat_q=4'b1011; z=0; match_cnt=0;
   - a full 1,0,1,1 is then required before the next pulse.
